// File: rtl/button_pkg.sv
// button_pkg: shared types and default constants for the push-button conditioner.
//   state_t              - debounce FSM state encoding (2 bits)
//   DEF_DEBOUNCE_CYCLES  - default stability window (40 ms at 12 MHz)
//   DEF_LONG_CYCLES      - default long-press hold time (1 s at 12 MHz)
//   DEF_CNT_W            - default width of the stability and long-press counters
package button_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 480000;
  localparam int DEF_LONG_CYCLES     = 12000000;
  localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   RST_VAL  - value both flops take in reset (idle level of the pin)
//   clk      - destination clock
//   rst      - asynchronous, active-high reset
//   d        - asynchronous input
//   q        - synchronised output, two clk edges behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RST_VAL;
      q     <= RST_VAL;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: turns a raw, bouncing, active-low push-button pin into a
// clean debounced level plus single-cycle press / release / long-press events.
//   clk            - system clock
//   rst            - asynchronous, active-high reset
//   btn_n          - raw button pin, low = pressed, asynchronous to clk
//   level          - debounced state, 1 = pressed
//   press          - one-cycle pulse when a press is accepted
//   release_pulse  - one-cycle pulse when a release is accepted
//                    (named this way because "release" is a reserved word)
//   long_press     - one-cycle pulse, once per press, LONG_CYCLES after press
// Build option: define LONG_PRESS_EN to build the long-press counter; without
// it long_press is tied low and LONG_CYCLES has no effect.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 ||
      LONG_CYCLES < 2 || LONG_CYCLES > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES/LONG_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync2;
  logic             btn;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Idle level of the pin is high, so the synchroniser resets to "released".
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (sync2)
  );

  assign btn = ~sync2;

  // Any disagreement with the stable state that does not persist for the whole
  // window drops back to the stable state, so the next edge restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_RELEASED: begin
          if (btn) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!btn) begin
            state <= S_RELEASED;
          end else if (cnt == DB_LAST) begin
            state <= S_PRESSED;
            press <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!btn) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (btn) begin
            state <= S_PRESSED;
          end else if (cnt == DB_LAST) begin
            state         <= S_RELEASED;
            release_pulse <= 1'b1;
            level         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] lcnt;
  logic             lp_done;  // long_press already fired for this press

  // lcnt parks at LONG_LAST; lp_done keeps the pulse to one per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt       <= '0;
      lp_done    <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!level) begin
        lcnt    <= '0;
        lp_done <= 1'b0;
      end else if (lcnt != LONG_LAST) begin
        lcnt <= lcnt + 1'b1;
      end else if (!lp_done) begin
        long_press <= 1'b1;
        lp_done    <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed segment table plus randomized stimulus, every
// cycle compared against a run-length model of the debounce rules.
module tb_button_debounce;

  localparam int D = 8;
  localparam int L = 32;
  localparam int W = 8;
`ifdef LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic level, press, release_pulse, long_press;

  int n_chk  = 0;
  int n_fail = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .CNT_W           (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  // Reference model: the pin reaches the decision logic two edges late; the
  // debounced level flips once the delayed pin has disagreed with it for
  // D+1 consecutive edges. long_press fires on the L-th edge of a high level.
  bit h1, h2, m_level, m_press, m_rel, m_long;
  int run, held;

  task automatic model_reset();
    h1 = 1'b1; h2 = 1'b1;
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    run = 0; held = 0;
  endtask

  task automatic model_step(input bit bn);
    bit b;
    b  = ~h2;
    h2 = h1;
    h1 = bn;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    if (m_level) held++; else held = 0;
    if (LP_ON && held == L) m_long = 1'b1;
    if (b != m_level) run++; else run = 0;
    if (run == D + 1) begin
      m_level = b;
      if (b) m_press = 1'b1; else m_rel = 1'b1;
      run = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, step model at posedge, compare #1 later.
  task automatic cycle(input bit bn, input bit r, input string tag,
                       output bit p, output bit rl, output bit lp);
    @(negedge clk);
    btn_n = bn;
    rst   = r;
    if (r) begin
      #1;
      model_reset();
      check({tag, " async reset outs"},
            int'({level, press, release_pulse, long_press}), 0);
    end
    @(posedge clk);
    if (r) model_reset(); else model_step(bn);
    #1;
    check({tag, " outs {lvl,prs,rel,long}"},
          int'({level, press, release_pulse, long_press}),
          int'({m_level, m_press, m_rel, m_long}));
    check({tag, " press&release exclusive"}, int'(press & release_pulse), 0);
    p  = press;
    rl = release_pulse;
    lp = long_press;
  endtask

  typedef struct {
    bit bn;
    bit r;
    int len;
    bit lvl;     // level at end of segment
    int np;      // press pulses in segment
    int nr;      // release pulses in segment
    int nl;      // long_press pulses in segment (enabled build)
    int first;   // cycle index of first press/release pulse, -1 none
    int lfirst;  // cycle index of long_press pulse, -1 none
  } seg_t;

  seg_t tbl[$];

  task automatic add(input bit bn, input bit r, input int len, input bit lvl,
                     input int np, input int nr, input int nl,
                     input int first, input int lfirst);
    seg_t s;
    s.bn = bn; s.r = r; s.len = len; s.lvl = lvl;
    s.np = np; s.nr = nr; s.nl = nl; s.first = first; s.lfirst = lfirst;
    tbl.push_back(s);
  endtask

  initial begin
    bit p, rl, lp;
    int cp, cr, cl, fi, lfi;
    string tag;

    model_reset();
    btn_n = 1'b1;
    rst   = 1'b1;
    #2;
    check("reset state outs", int'({level, press, release_pulse, long_press}), 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "reset", p, rl, lp);

    //   bn  r  len lvl np nr nl first lfirst
    add(1, 0,  5, 0, 0, 0, 0, -1, -1);  // idle
    add(0, 0, 20, 1, 1, 0, 0, 10, -1);  // clean press
    add(0, 0, 40, 1, 0, 0, 1, -1, 22);  // hold: long press 32 after press
    add(1, 0,  4, 1, 0, 0, 0, -1, -1);  // release attempt
    add(0, 0,  1, 1, 0, 0, 0, -1, -1);  // glitch back low
    add(1, 0, 20, 0, 0, 1, 0, 10, -1);  // real release
    add(0, 0,  3, 0, 0, 0, 0, -1, -1);  // bounce
    add(1, 0,  2, 0, 0, 0, 0, -1, -1);
    add(0, 0,  5, 0, 0, 0, 0, -1, -1);
    add(1, 0,  1, 0, 0, 0, 0, -1, -1);
    add(0, 0, 20, 1, 1, 0, 0, 10, -1);  // final fall held
    add(1, 0, 12, 0, 0, 1, 0, 10, -1);
    add(0, 0,  5, 0, 0, 0, 0, -1, -1);  // into press-wait
    add(0, 1,  2, 0, 0, 0, 0, -1, -1);  // reset mid-debounce
    add(1, 0,  3, 0, 0, 0, 0, -1, -1);
    add(0, 0, 15, 1, 1, 0, 0, 10, -1);  // press after reset
    add(0, 1,  2, 0, 0, 0, 0, -1, -1);  // reset while pressed
    add(1, 0, 12, 0, 0, 0, 0, -1, -1);  // no release pulse
    add(0, 0, 12, 1, 1, 0, 0, 10, -1);  // normal press again
    add(1, 0, 12, 0, 0, 1, 0, 10, -1);

    for (int s = 0; s < tbl.size(); s++) begin
      cp = 0; cr = 0; cl = 0; fi = -1; lfi = -1;
      tag = $sformatf("seg%0d", s);
      for (int c = 0; c < tbl[s].len; c++) begin
        cycle(tbl[s].bn, tbl[s].r, tag, p, rl, lp);
        if (p)  cp++;
        if (rl) cr++;
        if (lp) begin cl++; if (lfi < 0) lfi = c; end
        if ((p || rl) && fi < 0) fi = c;
      end
      check({tag, " end level"}, int'(level), int'(tbl[s].lvl));
      check({tag, " press count"}, cp, tbl[s].np);
      check({tag, " release count"}, cr, tbl[s].nr);
      check({tag, " long count"}, cl, LP_ON ? tbl[s].nl : 0);
      check({tag, " first pulse idx"}, fi, tbl[s].first);
      check({tag, " long pulse idx"}, lfi, LP_ON ? tbl[s].lfirst : -1);
    end

    // Randomized bouncing, long holds and occasional resets.
    for (int s = 0; s < 150; s++) begin
      bit bn, r;
      int len;
      bn  = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 30) == 0);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 50)
                                        : $urandom_range(1, 12);
      if (r) len = $urandom_range(1, 3);
      for (int c = 0; c < len; c++) cycle(bn, r, "rand", p, rl, lp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
